// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory handshake and the decode-side handoff.
// The fetch unit is the master; memory and decode together form the slave side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output ins, ins_valid, pc_out, pc_plus4, fetch_err,
        input  ins_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  ins, ins_valid, pc_out, pc_plus4, fetch_err,
        output ins_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding imem fetch, held instruction for decode.
// Optional macro FETCH_MISALIGN_CHECK_EN turns a misaligned redirect into a sticky fetch error.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        consume;
    logic [31:0] redir_tgt;

    assign consume   = vld_q && bus.ins_ready;
    assign redir_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        vld_d   = vld_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.imem_gnt) begin
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // Data arriving on the last allowed cycle still beats the timeout.
                if (bus.imem_rvalid) begin
                    ins_d   = bus.imem_rdata;
                    vld_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_HOLD: begin
                if (consume) begin
                    vld_d   = 1'b0;
                    ins_d   = NOP_INS;
                    state_d = S_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        pc_d = bus.redirect_valid ? redir_tgt : pc_q + 32'd4;
                    end
`else
                    pc_d = bus.redirect_valid ? redir_tgt : pc_q + 32'd4;
`endif
                end
            end
            S_ERR: begin
                vld_d = 1'b0;
                ins_d = NOP_INS;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ins_q   <= NOP_INS;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.imem_req  = (state_q == S_REQ);
    assign bus.imem_addr = pc_q;
    assign bus.ins       = ins_q;
    assign bus.ins_valid = vld_q;
    assign bus.pc_out    = pc_q;
    assign bus.pc_plus4  = pc_q + 32'd4;
    assign bus.fetch_err = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table for the main flow plus
// hand-written sequences for timeout, reset-in-WAIT and PC wrap.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    instr_fetch_unit_if ifa ();
    instr_fetch_unit_if ifb ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4), .NOP_INS(NOP))
        dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16), .NOP_INS(NOP))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    typedef struct {
        logic        rst, gnt, rvalid;
        logic [31:0] rdata;
        logic        ready, rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_ins, e_pc;
        logic        e_err;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vt[17];

    function automatic vec_t mk(logic r, logic g, logic rvl, logic [31:0] rd, logic rdy, logic rv,
                                logic [31:0] rpc, logic ereq, logic [31:0] eaddr, logic evld,
                                logic [31:0] eins, logic [31:0] epc, logic eerr);
        vec_t v;
        v.rst = r; v.gnt = g; v.rvalid = rvl; v.rdata = rd; v.ready = rdy; v.rv = rv; v.rpc = rpc;
        v.e_req = ereq; v.e_addr = eaddr; v.e_vld = evld; v.e_ins = eins; v.e_pc = epc; v.e_err = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(logic g, logic rv, logic [31:0] rd, logic rdy, logic rdv, logic [31:0] rpc);
        ifa.imem_gnt = g; ifa.imem_rvalid = rv; ifa.imem_rdata = rd;
        ifa.ins_ready = rdy; ifa.redirect_valid = rdv; ifa.redirect_pc = rpc;
    endtask

    task automatic drive_b(logic g, logic rv, logic [31:0] rd, logic rdy, logic rdv, logic [31:0] rpc);
        ifb.imem_gnt = g; ifb.imem_rvalid = rv; ifb.imem_rdata = rd;
        ifb.ins_ready = rdy; ifb.redirect_valid = rdv; ifb.redirect_pc = rpc;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);

        //          rst g rv rdata         rdy rv rpc            req addr          vld ins           pc            err
        vt[0]  = mk(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, NOP,          32'h0,        0);
        vt[1]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, NOP,          32'h0,        0);
        vt[2]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, NOP,          32'h0,        0);
        vt[3]  = mk(0, 0, 1, 32'h00500093, 0, 0, 32'h0,         0, 32'h0,        1, 32'h00500093, 32'h0,        0);
        vt[4]  = mk(0, 1, 1, 32'hDEADBEEF, 0, 0, 32'h0,         0, 32'h0,        1, 32'h00500093, 32'h0,        0);
        vt[5]  = mk(0, 0, 0, 32'h0,        0, 1, 32'h80,        0, 32'h0,        1, 32'h00500093, 32'h0,        0);
        vt[6]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h00500093, 32'h0,        0);
        vt[7]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h00500093, 32'h0,        0);
        vt[8]  = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h00500093, 32'h0,        0);
        vt[9]  = mk(0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h4,        0, NOP,          32'h4,        0);
        vt[10] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,        0, NOP,          32'h4,        0);
        vt[11] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h4,        0, NOP,          32'h4,        0);
        vt[12] = mk(0, 0, 1, 32'h11111111, 0, 0, 32'h0,         0, 32'h4,        1, 32'h11111111, 32'h4,        0);
        vt[13] = mk(0, 0, 0, 32'h0,        1, 1, 32'h40,        1, 32'h40,       0, NOP,          32'h40,       0);
        vt[14] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h40,       0, NOP,          32'h40,       0);
        vt[15] = mk(0, 0, 1, 32'h22222222, 0, 0, 32'h0,         0, 32'h40,       1, 32'h22222222, 32'h40,       0);
`ifdef FETCH_MISALIGN_CHECK_EN
        vt[16] = mk(0, 0, 0, 32'h0,        1, 1, 32'h42,        0, 32'h40,       0, NOP,          32'h40,       1);
`else
        vt[16] = mk(0, 0, 0, 32'h0,        1, 1, 32'h42,        1, 32'h40,       0, NOP,          32'h40,       0);
`endif

        for (int i = 0; i < 17; i++) begin
            rst_a = vt[i].rst;
            drive_a(vt[i].gnt, vt[i].rvalid, vt[i].rdata, vt[i].ready, vt[i].rv, vt[i].rpc);
            step();
            chk($sformatf("v%0d.req", i),   {31'd0, ifa.imem_req},  {31'd0, vt[i].e_req});
            chk($sformatf("v%0d.addr", i),  ifa.imem_addr,          vt[i].e_addr);
            chk($sformatf("v%0d.vld", i),   {31'd0, ifa.ins_valid}, {31'd0, vt[i].e_vld});
            chk($sformatf("v%0d.ins", i),   ifa.ins,                vt[i].e_ins);
            chk($sformatf("v%0d.pc", i),    ifa.pc_out,             vt[i].e_pc);
            chk($sformatf("v%0d.pc4", i),   ifa.pc_plus4,           vt[i].e_pc + 32'd4);
            chk($sformatf("v%0d.err", i),   {31'd0, ifa.fetch_err}, {31'd0, vt[i].e_err});
        end

        // Timeout: gnt then silence; error lands after exactly 4 WAIT cycles.
        rst_a = 1'b1; drive_a(0, 0, 0, 0, 0, 0); step();
        rst_a = 1'b0; step();
        drive_a(1, 0, 0, 0, 0, 0); step();
        drive_a(0, 0, 0, 0, 0, 0);
        step(); step(); step();
        chk("to.err_before", {31'd0, ifa.fetch_err}, 32'd0);
        step();
        chk("to.err_after", {31'd0, ifa.fetch_err}, 32'd1);
        chk("to.req_err",   {31'd0, ifa.imem_req},  32'd0);
        drive_a(1, 1, 32'hCAFEF00D, 1, 1, 32'h100);
        step(); step(); step();
        chk("to.sticky_err", {31'd0, ifa.fetch_err}, 32'd1);
        chk("to.sticky_req", {31'd0, ifa.imem_req},  32'd0);
        chk("to.sticky_vld", {31'd0, ifa.ins_valid}, 32'd0);
        chk("to.sticky_pc",  ifa.pc_out,             32'h0);
        rst_a = 1'b1; drive_a(0, 0, 0, 0, 0, 0); step();
        chk("to.rst_addr", ifa.imem_addr,          32'h0);
        chk("to.rst_err",  {31'd0, ifa.fetch_err}, 32'd0);

        // rvalid on the final allowed WAIT cycle still wins over the timeout.
        rst_a = 1'b0; step();
        drive_a(1, 0, 0, 0, 0, 0); step();
        drive_a(0, 0, 0, 0, 0, 0); step(); step(); step();
        drive_a(0, 1, 32'h0000ABCD, 0, 0, 0); step();
        chk("edge.vld", {31'd0, ifa.ins_valid}, 32'd1);
        chk("edge.ins", ifa.ins,                32'h0000ABCD);
        chk("edge.err", {31'd0, ifa.fetch_err}, 32'd0);
        rst_a = 1'b1; drive_a(0, 0, 0, 0, 0, 0); step();

        // PC wrap from 0xFFFFFFFC, then reset during WAIT.
        rst_b = 1'b0; step();
        chk("wr.addr0", ifb.imem_addr,          32'hFFFF_FFFC);
        chk("wr.req0",  {31'd0, ifb.imem_req},  32'd1);
        drive_b(1, 0, 0, 0, 0, 0); step();
        drive_b(0, 1, 32'h12345678, 0, 0, 0); step();
        chk("wr.vld",  {31'd0, ifb.ins_valid}, 32'd1);
        chk("wr.pc4",  ifb.pc_plus4,           32'h0);
        drive_b(0, 0, 0, 1, 0, 0); step();
        chk("wr.addr1", ifb.imem_addr,         32'h0);
        chk("wr.req1",  {31'd0, ifb.imem_req}, 32'd1);
        drive_b(1, 0, 0, 0, 0, 0); step();
        drive_b(0, 0, 0, 0, 0, 0);
        chk("wr.wait_req", {31'd0, ifb.imem_req}, 32'd0);
        rst_b = 1'b1; step();
        chk("wr.rst_vld",  {31'd0, ifb.ins_valid}, 32'd0);
        chk("wr.rst_req",  {31'd0, ifb.imem_req},  32'd0);
        chk("wr.rst_addr", ifb.imem_addr,          32'hFFFF_FFFC);
        chk("wr.rst_ins",  ifb.ins,                NOP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode/control unit.
- Owns the PC register and issues one word-aligned request at a time to instruction memory over a req/gnt/rvalid handshake.
- Holds the fetched instruction stable for decode until consumed.
- Selects the next PC: sequential PC+4, or a redirect target computed downstream for branch/JAL/JALR.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles in WAIT before a fetch error; valid range 2..255.
- NOP_INS, 32'h0000_0013, value driven on ins while no valid instruction is held (ADDI x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  request to instruction memory.
- imem_addr  out  32  word-aligned fetch address; equals pc while imem_req=1.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- ins  out  32  held instruction to decode (feeds opcode/func3/func7 decode).
- ins_valid  out  1  ins is valid.
- ins_ready  in  1  decode consumes ins this cycle.
- pc_out  out  32  PC of the held instruction.
- pc_plus4  out  32  pc_out+4, for the JAL/JALR link value.
- redirect_valid  in  1  take redirect_pc instead of PC+4; sampled only on consume.
- redirect_pc  in  32  branch/jump target.
- fetch_err  out  1  sticky fetch error.

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, ins=NOP_INS, ins_valid=0, fetch_err=0, timeout counter=0.
- Reset asserted in any state returns to these values on the next edge. Memory shares rst, so no stale rvalid follows reset.
- FSM states: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: the first cycle with rst=0 moves to REQ.
- REQ: imem_req=1 and imem_addr=pc, held stable until imem_gnt. On gnt, go to WAIT and clear the counter.
- WAIT: imem_req=0; counter increments each cycle.
  - On imem_rvalid: ins<=imem_rdata, ins_valid<=1, go to HOLD. rvalid in the same cycle the counter reaches TIMEOUT still wins.
  - If the counter reaches TIMEOUT without rvalid: fetch_err<=1, go to ERR.
- HOLD: ins, pc_out and ins_valid are held while ins_ready=0.
  - Consume = ins_valid && ins_ready.
  - On consume: pc<=redirect_valid ? {redirect_pc[31:2],2'b00} : pc+4; ins_valid<=0; ins<=NOP_INS; go to REQ.
- ERR: terminal until rst. imem_req=0, ins_valid=0.
- imem_gnt outside REQ and imem_rvalid outside WAIT are ignored.
- redirect_valid without consume is ignored; it does not modify pc.
- Arithmetic: pc+4 wraps modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000. pc_plus4 uses the same wrap.
- pc_out is the registered pc; it changes only on consume or reset.
- Minimum latency with gnt in the REQ cycle and rvalid in the next cycle:
  - Reset release to first ins_valid: 3 cycles.
  - Consume to next ins_valid: 3 cycles.
- One outstanding request maximum; no request issues while in HOLD.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- When defined: on consume with redirect_valid=1 and redirect_pc[1:0]!=2'b00, pc is not updated, fetch_err<=1, and the FSM goes to ERR.
- When undefined: redirect_pc[1:0] is silently forced to 2'b00 and no error is raised.

Test Plan:
- Reset, then gnt same cycle, rvalid next cycle with rdata=32'h00500093 -> imem_addr=0, ins=32'h00500093 and ins_valid=1 on the 3rd cycle after reset release, pc_plus4=4.
- Hold ins_ready=0 for 5 cycles, then 1 -> ins/pc_out unchanged for 5 cycles; next imem_addr=4; no second request before consume.
- Consume with redirect_valid=1, redirect_pc=32'h0000_0040 -> next imem_addr=32'h40. redirect_valid=1 without consume -> pc unchanged.
- TIMEOUT=4, gnt but never rvalid -> fetch_err=1 after 4 WAIT cycles; stays in ERR, imem_req=0 until rst; rst restores imem_addr=RESET_PC.
- RESET_PC=32'hFFFF_FFFC, sequential consume -> next imem_addr=0. rst asserted during WAIT -> next cycle ins_valid=0, imem_req=0, pc=RESET_PC.
- redirect_pc=32'h0000_0042 on consume -> with FETCH_MISALIGN_CHECK_EN: fetch_err=1, ERR; without: imem_addr=32'h40.
